knn_infer_scheduler: RTL and testbench

//   Round-robin scheduler sharing one KNN inference datapath (distance/sort stage + k_type voter) among
//   N_REQ query requesters. Grants one requester, pulses start to the datapath, tracks valid_sort then

---
 rtl/knn_infer_scheduler.sv | 171 +++++++++++++++++
 tb/tb_knn_infer_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_infer_scheduler.sv
// knn_infer_scheduler: round-robin arbiter in front of one shared KNN
// inference datapath. It grants a requester, launches the distance/sort
// stage, follows valid_sort and inference_done, and returns the voted
// label (or a timeout error) to the granted requester.
module knn_infer_scheduler #(
   parameter int N_REQ   = 4,
   parameter int TYPE_W  = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   output logic [$clog2(N_REQ)-1:0]  grant_id,
   output logic                      start_knn,
   input  logic                      valid_sort,
   input  logic                      inference_done,
   input  logic [TYPE_W-1:0]         inferred_type,
   output logic [N_REQ-1:0]          resp_valid,
   output logic [TYPE_W-1:0]         resp_type,
   output logic                      resp_err,
   output logic                      busy
);
   localparam int ID_W  = $clog2(N_REQ);
   // One spare count so the value reached on the expiry cycle never wraps.
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_GRANT, S_WAIT_SORT, S_WAIT_INFER, S_RESPOND
   } state_t;

   state_t             state_reg, state_next;
   logic [ID_W-1:0]    grant_reg, grant_next;
   logic [ID_W-1:0]    rr_ptr_reg, rr_ptr_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;

   logic [ID_W-1:0]    pick_id;
   logic [ID_W:0]      idx_w;
   logic               expire;
   logic               done_hit;
   logic [N_REQ-1:0]   grant_onehot_next;
   logic [N_REQ-1:0]   grant_onehot;

   logic [N_REQ-1:0]   req_ready_next;
   logic               start_knn_next;
   logic [N_REQ-1:0]   resp_valid_next;
   logic [TYPE_W-1:0]  resp_type_next;
   logic               resp_err_next;
   logic               busy_next;

   // Round-robin pick: scan from rr_ptr upward with wraparound; the loop runs
   // from the farthest offset down so the nearest requesting index wins.
   always_comb begin
      pick_id = '0;
      idx_w   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx_w = {1'b0, rr_ptr_reg} + (ID_W+1)'(i);
         if (idx_w >= (ID_W+1)'(N_REQ)) begin
            idx_w = idx_w - (ID_W+1)'(N_REQ);
         end
         if (req_valid[idx_w[ID_W-1:0]]) begin
            pick_id = idx_w[ID_W-1:0];
         end
      end
   end

   // The counter holds the number of cycles elapsed since the start pulse,
   // so expiry lands TIMEOUT cycles after start_knn.
   assign expire   = (cnt_reg == CNT_W'(TIMEOUT - 1));
   assign done_hit = (state_reg == S_WAIT_INFER) && inference_done;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign grant_onehot_next[gi] = (grant_next == ID_W'(gi));
      assign grant_onehot[gi]      = (grant_reg == ID_W'(gi));
   end

   // Next-state, grant latch, pointer advance and watchdog counter.
   always_comb begin
      state_next  = state_reg;
      grant_next  = grant_reg;
      rr_ptr_next = rr_ptr_reg;
      cnt_next    = '0;
      case (state_reg)
         S_IDLE: begin
            if (|req_valid) begin
               grant_next = pick_id;
               state_next = S_GRANT;
            end
         end
         S_GRANT: begin
            cnt_next   = cnt_reg + 1'b1;
            state_next = S_WAIT_SORT;
         end
         S_WAIT_SORT: begin
            cnt_next = cnt_reg + 1'b1;
            if (expire) begin
               state_next = S_RESPOND;
            end else if (valid_sort) begin
               state_next = S_WAIT_INFER;
            end
         end
         S_WAIT_INFER: begin
            cnt_next = cnt_reg + 1'b1;
            if (inference_done || expire) begin
               state_next = S_RESPOND;
            end
         end
         S_RESPOND: begin
            rr_ptr_next = (grant_reg == ID_W'(N_REQ - 1)) ? '0 : grant_reg + 1'b1;
            state_next  = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state so every port is a flop.
   always_comb begin
      req_ready_next  = '0;
      start_knn_next  = 1'b0;
      resp_valid_next = '0;
      resp_type_next  = '0;
      resp_err_next   = 1'b0;
      busy_next       = (state_next != S_IDLE);
      if (state_next == S_GRANT) begin
         req_ready_next = grant_onehot_next;
         start_knn_next = 1'b1;
      end
      if (state_next == S_RESPOND) begin
         resp_valid_next = grant_onehot;
         resp_err_next   = !done_hit;
         resp_type_next  = done_hit ? inferred_type : '0;
      end
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= S_IDLE;
         grant_reg  <= '0;
         rr_ptr_reg <= '0;
         cnt_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         grant_reg  <= grant_next;
         rr_ptr_reg <= rr_ptr_next;
         cnt_reg    <= cnt_next;
      end
   end

   // Registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_ready  <= '0;
         start_knn  <= 1'b0;
         resp_valid <= '0;
         resp_type  <= '0;
         resp_err   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         req_ready  <= req_ready_next;
         start_knn  <= start_knn_next;
         resp_valid <= resp_valid_next;
         resp_type  <= resp_type_next;
         resp_err   <= resp_err_next;
         busy       <= busy_next;
      end
   end

   assign grant_id = grant_reg;

endmodule

// File: tb/tb_knn_infer_scheduler.sv
// Bench for knn_infer_scheduler: a behavioural datapath driver plus a
// reference model of arbitration order and response timing.
module tb_knn_infer_scheduler;
   localparam int N  = 4;
   localparam int TW = 2;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req_valid = '0;
   logic [N-1:0]  req_ready;
   logic [1:0]    grant_id;
   logic          start_knn;
   logic          valid_sort = 1'b0;
   logic          inference_done = 1'b0;
   logic [TW-1:0] inferred_type = '0;
   logic [N-1:0]  resp_valid;
   logic [TW-1:0] resp_type;
   logic          resp_err;
   logic          busy;

   knn_infer_scheduler #(.N_REQ(N), .TYPE_W(TW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .grant_id(grant_id), .start_knn(start_knn), .valid_sort(valid_sort),
      .inference_done(inference_done), .inferred_type(inferred_type),
      .resp_valid(resp_valid), .resp_type(resp_type), .resp_err(resp_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int model_rr  = 0;
   int job_no    = 0;

   // Observations of the most recent job.
   int         j_wait, j_k;
   logic [N-1:0] j_ready, j_resp, j_after_resp;
   logic [1:0] j_gid;
   logic [TW-1:0] j_type;
   logic       j_err, j_busy, j_busy_ok, j_stable, j_quiet, j_after_busy;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: first requesting index scanning upward from the pointer.
   function automatic int model_grant(input logic [N-1:0] m, input int rr);
      for (int i = 0; i < N; i++) begin
         if (m[(rr + i) % N]) return (rr + i) % N;
      end
      return -1;
   endfunction

   // Model: a job answers normally only if the sort lands while still
   // waiting for it (before expiry) and the result arrives strictly later,
   // no later than TO-1 cycles after start. Otherwise: error at TO.
   function automatic bit model_done_ok(input int sd, input int dd);
      return (sd >= 1) && (sd <= TO - 2) && (dd > sd) && (dd <= TO - 1);
   endfunction

   function automatic logic [N-1:0] onehot(input int g);
      logic [N-1:0] v;
      v = '0;
      v[g] = 1'b1;
      return v;
   endfunction

   // Drives one job through the datapath. sd/dd are the cycles after the
   // start pulse at which valid_sort / inference_done pulse (0 = never).
   task automatic run_job(input int sd, input int dd, input logic [TW-1:0] typ,
                          input bit drop, input logic [N-1:0] next_mask);
      bit started;
      started = 0;
      j_k = -1;
      j_wait = 0;
      for (int w = 1; w <= 8; w++) begin
         tick();
         j_wait = w;
         if (start_knn === 1'b1) begin
            started = 1;
            break;
         end
      end
      j_ready = req_ready;
      j_gid   = grant_id;
      j_busy  = busy;
      if (drop) req_valid = req_valid & ~req_ready;
      j_busy_ok = 1; j_stable = 1; j_quiet = 1;
      j_resp = '0; j_type = '0; j_err = 1'b0;
      if (started) begin
         for (int k = 1; k <= TO + 8; k++) begin
            tick();
            valid_sort     = (k == sd);
            inference_done = (k == dd);
            inferred_type  = (k == dd) ? typ : TW'($urandom);
            if (busy !== 1'b1) j_busy_ok = 0;
            if (grant_id !== j_gid) j_stable = 0;
            if (req_ready !== '0 || start_knn !== 1'b0) j_quiet = 0;
            if (resp_valid !== '0) begin
               j_k = k; j_resp = resp_valid; j_type = resp_type; j_err = resp_err;
               req_valid = next_mask;
               break;
            end
         end
      end
      valid_sort = 1'b0;
      inference_done = 1'b0;
      tick();
      j_after_busy = busy;
      j_after_resp = resp_valid;
      $display("job %0d: grant=%0d wait=%0d resp@+%0d resp_valid=%b type=%0d err=%0d",
               job_no, j_gid, j_wait, j_k, j_resp, j_type, j_err);
      job_no++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = '0;
      repeat (3) tick();
      total_cnt++;
      if ({req_ready, grant_id, start_knn, resp_valid, resp_type, resp_err, busy} !== '0)
         $display("FAIL reset_outputs: got %b want 0",
                  {req_ready, grant_id, start_knn, resp_valid, resp_type, resp_err, busy});
      else pass_cnt++;
      rst = 1'b0;
      model_rr = 0;
      repeat (2) tick();
      total_cnt++;
      if (busy !== 1'b0 || start_knn !== 1'b0)
         $display("FAIL reset_idle: busy=%b start=%b want 0 0", busy, start_knn);
      else pass_cnt++;
   endtask

   task automatic test_basic();
      int g;
      req_valid = 4'b0001;
      g = model_grant(req_valid, model_rr);
      run_job(5, 8, 2'd2, 1, 4'b0000);
      model_rr = (g + 1) % N;
      total_cnt++;
      if (j_wait !== 1) $display("FAIL basic_latency: got %0d want 1", j_wait); else pass_cnt++;
      total_cnt++;
      if (j_ready !== 4'b0001 || j_busy !== 1'b1)
         $display("FAIL basic_ready: ready=%b busy=%b want 0001 1", j_ready, j_busy);
      else pass_cnt++;
      total_cnt++;
      if (j_k !== 9) $display("FAIL basic_resp_time: got %0d want 9", j_k); else pass_cnt++;
      total_cnt++;
      if (j_resp !== 4'b0001 || j_type !== 2'd2 || j_err !== 1'b0)
         $display("FAIL basic_resp: valid=%b type=%0d err=%b want 0001 2 0", j_resp, j_type, j_err);
      else pass_cnt++;
      total_cnt++;
      if (!j_busy_ok || !j_stable || !j_quiet)
         $display("FAIL basic_inflight: busy_ok=%0d stable=%0d quiet=%0d want 1 1 1",
                  j_busy_ok, j_stable, j_quiet);
      else pass_cnt++;
      total_cnt++;
      if (j_after_busy !== 1'b0 || j_after_resp !== '0)
         $display("FAIL basic_after: busy=%b resp=%b want 0 0000", j_after_busy, j_after_resp);
      else pass_cnt++;
   endtask

   task automatic test_round_robin();
      int g;
      req_valid = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         g = model_grant(req_valid, model_rr);
         run_job(2, 4, TW'(j), 0, (j == 4) ? 4'b0000 : 4'b1111);
         model_rr = (g + 1) % N;
         total_cnt++;
         if (j_gid !== 2'(g) || j_ready !== onehot(g) || j_wait !== 1)
            $display("FAIL rr_grant job %0d: id=%0d ready=%b wait=%0d want %0d %b 1",
                     j, j_gid, j_ready, j_wait, g, onehot(g));
         else pass_cnt++;
         total_cnt++;
         if (j_resp !== onehot(g) || j_type !== TW'(j) || j_err !== 1'b0)
            $display("FAIL rr_resp job %0d: valid=%b type=%0d err=%b want %b %0d 0",
                     j, j_resp, j_type, j_err, onehot(g), j);
         else pass_cnt++;
      end
   endtask

   task automatic test_wrap();
      int g;
      logic [N-1:0] masks [3];
      masks[0] = 4'b0010; masks[1] = 4'b0011; masks[2] = 4'b0011;
      for (int j = 0; j < 3; j++) begin
         req_valid = masks[j];
         g = model_grant(req_valid, model_rr);
         run_job(1, 3, 2'd1, 1, 4'b0000);
         model_rr = (g + 1) % N;
         total_cnt++;
         if (j_gid !== 2'(g) || j_resp !== onehot(g))
            $display("FAIL wrap_grant step %0d: id=%0d resp=%b want %0d %b",
                     j, j_gid, j_resp, g, onehot(g));
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid_job();
      bit seen;
      req_valid = 4'b0100;
      seen = 0;
      for (int w = 0; w < 8 && !seen; w++) begin
         tick();
         if (start_knn === 1'b1) seen = 1;
      end
      total_cnt++;
      if (!seen) $display("FAIL rstmid_start: got none want start_knn"); else pass_cnt++;
      req_valid = '0;
      tick(); valid_sort = 1'b1;
      tick(); valid_sort = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total_cnt++;
      if ({req_ready, grant_id, start_knn, resp_valid, resp_type, resp_err, busy} !== '0)
         $display("FAIL rstmid_outputs: got %b want 0",
                  {req_ready, grant_id, start_knn, resp_valid, resp_type, resp_err, busy});
      else pass_cnt++;
      model_rr = 0;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         inference_done = (c == 2);
         inferred_type  = 2'd3;
         tick();
         if (resp_valid !== '0 || busy !== 1'b0) seen = 1;
      end
      inference_done = 1'b0;
      total_cnt++;
      if (seen) $display("FAIL rstmid_no_resp: got activity want none"); else pass_cnt++;
      req_valid = 4'b1001;
      run_job(1, 2, 2'd1, 1, 4'b0000);
      model_rr = 1;
      total_cnt++;
      if (j_gid !== 2'd0 || j_resp !== 4'b0001)
         $display("FAIL rstmid_regrant: id=%0d resp=%b want 0 0001", j_gid, j_resp);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      int g;
      bit seen;
      req_valid = 4'b0100;
      g = model_grant(req_valid, model_rr);
      run_job(0, 0, 2'd0, 1, 4'b0000);
      model_rr = (g + 1) % N;
      total_cnt++;
      if (j_k !== TO) $display("FAIL timeout_time: got %0d want %0d", j_k, TO); else pass_cnt++;
      total_cnt++;
      if (j_resp !== onehot(g) || j_err !== 1'b1 || j_type !== '0)
         $display("FAIL timeout_resp: valid=%b err=%b type=%0d want %b 1 0",
                  j_resp, j_err, j_type, onehot(g));
      else pass_cnt++;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         valid_sort     = (c == 0);
         inference_done = (c == 1);
         inferred_type  = 2'd3;
         tick();
         if (resp_valid !== '0 || busy !== 1'b0 || start_knn !== 1'b0) seen = 1;
      end
      valid_sort = 1'b0; inference_done = 1'b0;
      total_cnt++;
      if (seen) $display("FAIL timeout_late_done: got activity want none"); else pass_cnt++;
   endtask

   task automatic test_expiry_done();
      int g;
      req_valid = 4'b1000;
      g = model_grant(req_valid, model_rr);
      run_job(3, TO - 1, 2'd3, 1, 4'b0000);
      model_rr = (g + 1) % N;
      total_cnt++;
      if (j_k !== TO || j_err !== 1'b0 || j_type !== 2'd3)
         $display("FAIL expiry_done_wins: at=%0d err=%b type=%0d want %0d 0 3",
                  j_k, j_err, j_type, TO);
      else pass_cnt++;
      req_valid = 4'b0010;
      g = model_grant(req_valid, model_rr);
      run_job(3, TO, 2'd3, 1, 4'b0000);
      model_rr = (g + 1) % N;
      total_cnt++;
      if (j_k !== TO || j_err !== 1'b1 || j_type !== '0)
         $display("FAIL expiry_late_done: at=%0d err=%b type=%0d want %0d 1 0",
                  j_k, j_err, j_type, TO);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int g, sd, dd, mode, ek;
      logic [TW-1:0] typ, et;
      logic [N-1:0] nxt;
      bit ok;
      req_valid = N'($urandom_range(1, 15));
      for (int j = 0; j < 14; j++) begin
         mode = $urandom_range(0, 4);
         sd = $urandom_range(1, 6);
         case (mode)
            0, 1: dd = $urandom_range(sd + 1, TO - 1);
            2:    begin sd = 0; dd = $urandom_range(1, TO); end
            3:    dd = $urandom_range(1, sd);
            default: begin sd = $urandom_range(TO - 3, TO - 1); dd = $urandom_range(sd, TO); end
         endcase
         typ = TW'($urandom);
         nxt = N'($urandom_range(1, 15));
         if (j == 13) nxt = '0;
         g  = model_grant(req_valid, model_rr);
         ok = model_done_ok(sd, dd);
         ek = ok ? dd + 1 : TO;
         et = ok ? typ : '0;
         run_job(sd, dd, typ, 1, nxt);
         model_rr = (g + 1) % N;
         total_cnt++;
         if (j_gid !== 2'(g) || j_ready !== onehot(g) || j_wait !== 1)
            $display("FAIL rnd_grant job %0d: id=%0d ready=%b wait=%0d want %0d %b 1",
                     j, j_gid, j_ready, j_wait, g, onehot(g));
         else pass_cnt++;
         total_cnt++;
         if (j_k !== ek || j_resp !== onehot(g))
            $display("FAIL rnd_resp_time job %0d (sd=%0d dd=%0d): at=%0d valid=%b want %0d %b",
                     j, sd, dd, j_k, j_resp, ek, onehot(g));
         else pass_cnt++;
         total_cnt++;
         if (j_type !== et || j_err !== !ok)
            $display("FAIL rnd_resp_data job %0d: type=%0d err=%b want %0d %b",
                     j, j_type, j_err, et, !ok);
         else pass_cnt++;
         total_cnt++;
         if (!j_busy_ok || !j_stable || !j_quiet || j_after_busy !== 1'b0 || j_after_resp !== '0)
            $display("FAIL rnd_inflight job %0d: busy_ok=%0d stable=%0d quiet=%0d after_busy=%b want 1 1 1 0",
                     j, j_busy_ok, j_stable, j_quiet, j_after_busy);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_wrap();
      test_reset_mid_job();
      test_timeout();
      test_expiry_done();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
